// File: rtl/ifsched_pkg.sv
// ifsched_pkg: row-mode codes, FSM states and sram_top codes
// shared by the ifmap ping-pong scheduler and its write issuer.
package ifsched_pkg;

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] LOAD         = 3'd1;
  localparam logic [2:0] UP_PADDING   = 3'd2;
  localparam logic [2:0] THREEROW     = 3'd3;
  localparam logic [2:0] TWOROW       = 3'd4;
  localparam logic [2:0] ONEROW       = 3'd5;
  localparam logic [2:0] DOWN_PADDING = 3'd6;

  typedef enum logic [1:0] {
    W_IDLE,
    W_START,
    W_BUSY
  } w_state_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_WAIT,
    R_START,
    R_BUSY,
    R_FIN
  } r_state_t;

  localparam logic [1:0] TOP_NONE = 2'd0;
  localparam logic [1:0] TOP_B0   = 2'd1;
  localparam logic [1:0] TOP_B1   = 2'd2;

endpackage

// File: rtl/ifsram_wr_issue.sv
// ifsram_wr_issue: write-side FSM, bank full flags, wr_bank, tile count.
// Ports: clr/run frame control, rel/rel_bank release, engine start/busy/done.
module ifsram_wr_issue
  import ifsched_pkg::*;
#(
  parameter int TN_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            run,
  input  logic [TN_W-1:0] tile_num,
  input  logic            rel,
  input  logic            rel_bank,
  input  logic            if_write_busy,
  input  logic            if_write_done,
  output logic            if_write_start,
  output logic            sram0_write,
  output logic            sram1_write,
  output logic [1:0]      full,
  output logic            first_done
);

  w_state_t        state, state_n;
  logic            wr_bank;
  logic [TN_W-1:0] tiles;
  logic            done_ok;
  logic            active;

  assign done_ok = (state == W_BUSY) && if_write_done;
  assign active  = (state != W_IDLE);
  assign sram0_write = active && !wr_bank;
  assign sram1_write = active && wr_bank;
  assign first_done  = done_ok && (tiles == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= W_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n        = state;
    if_write_start = 1'b0;
    unique case (state)
      W_IDLE:
        if (run && (tiles < tile_num) &&
            !full[wr_bank] && !if_write_busy)
          state_n = W_START;
      W_START: begin
        if_write_start = 1'b1;
        state_n        = W_BUSY;
      end
      W_BUSY:
        if (if_write_done) state_n = W_IDLE;
      default: state_n = W_IDLE;
    endcase
  end

  // Release and fill never hit the same bank in one cycle.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      tiles   <= '0;
    end else begin
      if (rel) full[rel_bank] <= 1'b0;
      if (done_ok) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
        tiles         <= tiles + TN_W'(1);
      end
    end
  end

endmodule

// File: rtl/ifsram_pp_sched.sv
// ifsram_pp_sched: ping-pong ifmap SRAM scheduler (write/read issue,
// row modes, bank selects). IFSCHED_PERF_EN builds the stall counter.
module ifsram_pp_sched
  import ifsched_pkg::*;
#(
  parameter int TN_W   = 8,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [TN_W-1:0]   cfg_tile_num,
  output logic              if_write_start,
  input  logic              if_write_busy,
  input  logic              if_write_done,
  output logic              if_read_start,
  input  logic              if_read_busy,
  input  logic              if_read_done,
  input  logic              change_sram,
  input  logic              row_finish,
  output logic              ifsram0_write,
  output logic              ifsram1_write,
  output logic              ifsram0_read,
  output logic              ifsram1_read,
  output logic [2:0]        current_state,
  output logic [1:0]        sram_top,
  output logic              sched_busy,
  output logic              sched_done,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  r_state_t        state, state_n;
  logic [TN_W-1:0] n, bidx, last;
  logic [2:0]      mode, mode_n;
  logic            top, change_time;
  logic            go, ready, rd_done, rel;
  logic            rd_act, pair, sel_bank, rd_en;
  logic [1:0]      full;
  logic            first_done;

  assign go      = (state == R_IDLE) && start;
  assign last    = n - TN_W'(1);
  assign rd_done = (state == R_BUSY) && if_read_done;
  assign pair    = (mode == TWOROW) || (mode == ONEROW);
  assign rel     = rd_done &&
                   ((mode == ONEROW) || (mode == DOWN_PADDING));
  assign ready   = pair ? (&full) : full[top];
  assign rd_act  = (state == R_START) || (state == R_BUSY);

  assign sched_busy    = (state != R_IDLE);
  assign sched_done    = (state == R_FIN);
  assign current_state = rd_act ? mode : IDLE;

  // Two-bank passes follow the read engine across the bank boundary.
  assign sel_bank     = top ^ (pair && change_time);
  assign rd_en        = rd_act && if_read_busy;
  assign ifsram0_read = rd_en && !sel_bank;
  assign ifsram1_read = rd_en && sel_bank;

  ifsram_wr_issue #(.TN_W(TN_W)) u_wr (
    .clk            (clk),
    .reset          (reset),
    .clr            (go),
    .run            (sched_busy),
    .tile_num       (n),
    .rel            (rel),
    .rel_bank       (top),
    .if_write_busy  (if_write_busy),
    .if_write_done  (if_write_done),
    .if_write_start (if_write_start),
    .sram0_write    (ifsram0_write),
    .sram1_write    (ifsram1_write),
    .full           (full),
    .first_done     (first_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= R_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    if_read_start = 1'b0;
    unique case (state)
      R_IDLE:
        if (start)
          state_n = (cfg_tile_num == '0) ? R_FIN : R_WAIT;
      R_WAIT:
        if (ready) state_n = R_START;
      R_START: begin
        if_read_start = 1'b1;
        state_n       = R_BUSY;
      end
      R_BUSY:
        if (if_read_done)
          state_n = (mode == DOWN_PADDING) ? R_FIN : R_WAIT;
      R_FIN:   state_n = R_IDLE;
      default: state_n = R_IDLE;
    endcase
  end

  always_comb begin
    mode_n = mode;
    unique case (mode)
      UP_PADDING:
        mode_n = (last == '0) ? DOWN_PADDING : THREEROW;
      THREEROW: mode_n = TWOROW;
      TWOROW:   mode_n = ONEROW;
      ONEROW:
        mode_n = (bidx == last) ? DOWN_PADDING : THREEROW;
      default:  mode_n = mode;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n           <= '0;
      mode        <= UP_PADDING;
      bidx        <= '0;
      top         <= 1'b0;
      sram_top    <= TOP_NONE;
      change_time <= 1'b0;
    end else begin
      if (go) begin
        n        <= cfg_tile_num;
        mode     <= UP_PADDING;
        bidx     <= TN_W'(1);
        top      <= 1'b0;
        sram_top <= TOP_NONE;
      end
      if (rd_done) begin
        mode <= mode_n;
        if (mode == ONEROW) bidx <= bidx + TN_W'(1);
      end
      if (first_done)
        sram_top <= top ? TOP_B1 : TOP_B0;
      if (rel) begin
        top <= ~top;
        if (mode == DOWN_PADDING) sram_top <= TOP_NONE;
        else sram_top <= top ? TOP_B0 : TOP_B1;
      end
      if (state == R_START)  change_time <= 1'b0;
      else if (change_sram)  change_time <= 1'b1;
      else if (row_finish)   change_time <= 1'b0;
    end
  end

`ifdef IFSCHED_PERF_EN
  logic [PERF_W-1:0] stall;
  always_ff @(posedge clk) begin
    if (reset || go)
      stall <= '0;
    else if ((state == R_WAIT) && !ready && !(&stall))
      stall <= stall + PERF_W'(1);
  end
  assign perf_stall_cnt = stall;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifsram_pp_sched.sv
// tb_ifsram_pp_sched: scoreboard bench for ifsram_pp_sched with
// write/read engine models and per-scenario test tasks.
module tb_ifsram_pp_sched;
  import ifsched_pkg::*;

  localparam int TN_W   = 8;
  localparam int PERF_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [TN_W-1:0] cfg_tile_num = '0;
  logic if_write_start, if_read_start;
  logic if_write_busy = 1'b0, if_write_done = 1'b0;
  logic if_read_busy = 1'b0, if_read_done = 1'b0;
  logic change_sram = 1'b0, row_finish = 1'b0;
  logic ifsram0_write, ifsram1_write;
  logic ifsram0_read, ifsram1_read;
  logic [2:0] current_state;
  logic [1:0] sram_top;
  logic sched_busy, sched_done;
  logic [PERF_W-1:0] perf_stall_cnt;

  int tests = 0, fails = 0;
  int wdelay = 10, rdelay = 10;
  int wcnt = 0, rcnt = 0;

  always #5 clk = ~clk;

  ifsram_pp_sched #(.TN_W(TN_W), .PERF_W(PERF_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_tile_num   (cfg_tile_num),
    .if_write_start (if_write_start),
    .if_write_busy  (if_write_busy),
    .if_write_done  (if_write_done),
    .if_read_start  (if_read_start),
    .if_read_busy   (if_read_busy),
    .if_read_done   (if_read_done),
    .change_sram    (change_sram),
    .row_finish     (row_finish),
    .ifsram0_write  (ifsram0_write),
    .ifsram1_write  (ifsram1_write),
    .ifsram0_read   (ifsram0_read),
    .ifsram1_read   (ifsram1_read),
    .current_state  (current_state),
    .sram_top       (sram_top),
    .sched_busy     (sched_busy),
    .sched_done     (sched_done),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always @(negedge clk) begin
    if (reset) begin
      if_write_busy = 1'b0; if_write_done = 1'b0;
    end else if (if_write_done) begin
      if_write_busy = 1'b0; if_write_done = 1'b0;
    end else if (if_write_start) begin
      if_write_busy = 1'b1; wcnt = wdelay;
    end else if (if_write_busy) begin
      wcnt--;
      if (wcnt <= 0) if_write_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if_read_busy = 1'b0; if_read_done = 1'b0;
    end else if (if_read_done) begin
      if_read_busy = 1'b0; if_read_done = 1'b0;
    end else if (if_read_start) begin
      if_read_busy = 1'b1; rcnt = rdelay;
    end else if (if_read_busy) begin
      rcnt--;
      if (rcnt <= 0) if_read_done = 1'b1;
    end
  end

  typedef struct packed {
    logic [2:0] mode;
    logic [1:0] top;
  } pass_t;

  pass_t exp_q[$];
  int cyc = 0, wr_n = 0, rd_n = 0, done_n = 0;
  int occ = 0, widx = 0, wait_cyc = 0, passes = 0;
  int rel_cyc = -1, wr3_cyc = -1, need = 0;
  logic rd_active = 1'b0, prev_busy = 1'b0, ovl = 1'b0;
  logic [2:0] cur_mode = 3'd0;
  logic [1:0] wsel;

  always @(posedge clk) begin
    pass_t p;
    #1;
    cyc++;
    if (reset) begin
      exp_q.delete();
      rd_active = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (sched_busy && !prev_busy) begin
        occ = 0; widx = 0; wait_cyc = 0; passes = 0;
        rel_cyc = -1; wr3_cyc = -1; ovl = 1'b0;
      end
      prev_busy = sched_busy;
      if (sched_busy && !sched_done &&
          !if_read_start && !rd_active)
        wait_cyc++;
      if (ifsram1_write && if_read_busy &&
          current_state == UP_PADDING)
        ovl = 1'b1;
      if (if_write_start) begin
        wr_n++;
        tests++;
        wsel = (widx % 2 == 1) ? 2'b10 : 2'b01;
        if ({ifsram1_write, ifsram0_write} !== wsel) begin
          fails++;
          $display("FAIL wr_sel tile %0d: got %b want %b",
                   widx, {ifsram1_write, ifsram0_write}, wsel);
        end
        widx++;
        if (widx == 3) wr3_cyc = cyc;
      end
      if (if_write_done) occ++;
      if (if_read_start) begin
        rd_n++; passes++; rd_active = 1'b1;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rd_extra: got mode %0d want none",
                   current_state);
        end else begin
          p = exp_q.pop_front();
          cur_mode = p.mode;
          if (current_state !== p.mode ||
              sram_top !== p.top) begin
            fails++;
            $display("FAIL pass: got mode %0d top %0d want %0d %0d",
                     current_state, sram_top, p.mode, p.top);
          end
        end
        tests++;
        need = (cur_mode == TWOROW || cur_mode == ONEROW) ? 2 : 1;
        if (occ < need) begin
          fails++;
          $display("FAIL rd_ready: got %0d full want %0d",
                   occ, need);
        end
      end
      if (if_read_done && rd_active) begin
        rd_active = 1'b0;
        if (cur_mode == ONEROW || cur_mode == DOWN_PADDING) begin
          occ--;
          if (rel_cyc < 0) rel_cyc = cyc;
        end
      end
      if (sched_done) done_n++;
    end
  end

  task automatic push_frame(input int n);
    pass_t p;
    p.mode = UP_PADDING; p.top = 2'd1;
    exp_q.push_back(p);
    for (int i = 1; i < n; i++) begin
      p.top = ((i - 1) % 2 == 1) ? 2'd2 : 2'd1;
      p.mode = THREEROW; exp_q.push_back(p);
      p.mode = TWOROW;   exp_q.push_back(p);
      p.mode = ONEROW;   exp_q.push_back(p);
    end
    p.mode = DOWN_PADDING;
    p.top = ((n - 1) % 2 == 1) ? 2'd2 : 2'd1;
    exp_q.push_back(p);
  endtask

  task automatic start_frame(input int n);
    @(negedge clk);
    cfg_tile_num = TN_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!sched_done && k < 20000) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (!sched_done) begin
      fails++;
      $display("FAIL %s_timeout: got no done want done", tag);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    logic [12:0] o;
    o = {if_write_start, if_read_start, ifsram0_write,
         ifsram1_write, ifsram0_read, ifsram1_read,
         current_state, sram_top, sched_busy, sched_done};
    tests++;
    if (o !== 13'd0) begin
      fails++;
      $display("FAIL %s_outs: got %h want 0", tag, o);
    end
    tests++;
    if (perf_stall_cnt !== '0) begin
      fails++;
      $display("FAIL %s_perf: got %0d want 0", tag, perf_stall_cnt);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("post_reset");
  endtask

  task automatic test_n0;
    int w0 = wr_n;
    @(negedge clk);
    cfg_tile_num = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("n0_done_pulse", int'(sched_done), 1);
    @(negedge clk);
    chk("n0_done_low", int'(sched_done), 0);
    chk("n0_busy_low", int'(sched_busy), 0);
    repeat (5) @(negedge clk);
    chk("n0_no_write", wr_n - w0, 0);
  endtask

  task automatic test_n1;
    int w0 = wr_n, r0 = rd_n, d0 = done_n;
    wdelay = 10; rdelay = 10;
    push_frame(1);
    start_frame(1);
    wait_done("n1");
    chk("n1_writes", wr_n - w0, 1);
    chk("n1_reads", rd_n - r0, 2);
    chk("n1_dones", done_n - d0, 1);
    chk("n1_top_end", int'(sram_top), 0);
    chk("n1_busy_end", int'(sched_busy), 0);
    chk("n1_q_empty", exp_q.size(), 0);
  endtask

  task automatic test_n2;
    int w0 = wr_n, r0 = rd_n, d0 = done_n;
    wdelay = 10; rdelay = 10;
    push_frame(2);
    start_frame(2);
    repeat (5) @(negedge clk);
    cfg_tile_num = TN_W'(5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("n2");
    chk("n2_writes", wr_n - w0, 2);
    chk("n2_reads", rd_n - r0, 5);
    chk("n2_dones", done_n - d0, 1);
    chk("n2_overlap", int'(ovl), 1);
    chk("n2_q_empty", exp_q.size(), 0);
  endtask

  task automatic test_n3;
    int w0 = wr_n, r0 = rd_n;
    wdelay = 10; rdelay = 40;
    push_frame(3);
    start_frame(3);
    wait_done("n3");
    chk("n3_writes", wr_n - w0, 3);
    chk("n3_reads", rd_n - r0, 8);
    chk("n3_rel_seen", int'(rel_cyc >= 0), 1);
    chk("n3_wr3_after_rel", int'(wr3_cyc > rel_cyc), 1);
    chk("n3_top_end", int'(sram_top), 0);
  endtask

  task automatic test_change;
    int k = 0;
    wdelay = 10; rdelay = 30;
    push_frame(2);
    start_frame(2);
    while (!(if_read_start && current_state == TWOROW) &&
           k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("chg_found", int'(current_state), int'(TWOROW));
    repeat (3) @(negedge clk);
    chk("chg_top_sel", {ifsram1_read, ifsram0_read}, 1);
    change_sram = 1'b1;
    @(negedge clk);
    change_sram = 1'b0;
    chk("chg_other_sel", {ifsram1_read, ifsram0_read}, 2);
    @(negedge clk);
    chk("chg_hold", {ifsram1_read, ifsram0_read}, 2);
    row_finish = 1'b1;
    @(negedge clk);
    row_finish = 1'b0;
    chk("chg_back_top", {ifsram1_read, ifsram0_read}, 1);
    change_sram = 1'b1;
    row_finish = 1'b1;
    @(negedge clk);
    change_sram = 1'b0;
    row_finish = 1'b0;
    chk("chg_set_wins", {ifsram1_read, ifsram0_read}, 2);
    wait_done("chg");
    chk("chg_q_empty", exp_q.size(), 0);
  endtask

  task automatic test_reset_mid;
    int k = 0;
    int r0;
    wdelay = 10; rdelay = 40;
    push_frame(3);
    start_frame(3);
    while (!(current_state == THREEROW && if_read_busy) &&
           k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid_found", int'(current_state), int'(THREEROW));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_outputs("rst_mid");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    r0 = rd_n;
    wdelay = 10; rdelay = 10;
    push_frame(1);
    start_frame(1);
    wait_done("rst_mid_n1");
    chk("rst_mid_reads", rd_n - r0, 2);
    chk("rst_mid_top_end", int'(sram_top), 0);
  endtask

  task automatic test_perf;
    int want;
    wdelay = 50; rdelay = 10;
    push_frame(2);
    start_frame(2);
    wait_done("perf");
`ifdef IFSCHED_PERF_EN
    want = wait_cyc - passes;
`else
    want = 0;
`endif
    chk("perf_stall", int'(perf_stall_cnt), want);
  endtask

  initial begin
    test_reset();
    test_n0();
    test_n1();
    test_n2();
    test_n3();
    test_change();
    test_reset_mid();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
